// File: rtl/fpu_compare_issue.sv
// Issue/response front end for the FPU comparison unit: decodes a compare or min/max request,
// drives the comparator from registered operands and returns an IEEE-corrected, tagged response.
`timescale 1ns/1ps
module fpu_compare_issue #(
    parameter int Std   = 31,
    parameter int Exp   = 7,
    parameter int Man   = 22,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_funct5,
    input  logic [2:0]       req_funct3,
    input  logic [Std:0]     req_rs1,
    input  logic [Std:0]     req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [7:0]       cmp_opcode,
    output logic [Std:0]     cmp_a,
    output logic [Std:0]     cmp_b,
    input  logic [31:0]      cmp_result,
    input  logic [Std:0]     cmp_minmax,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [Std:0]     rsp_data,
    output logic             rsp_nv,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             illegal_p0;
    logic [TAG_W-1:0] tag_p0;
    logic [7:0]       dec_op;
    logic [Std+1:0]   fix_p0;
    logic             unused_cmp_hi;

    assign unused_cmp_hi = |cmp_result[31:1];

    function automatic logic [7:0] decode(input logic [4:0] f5, input logic [2:0] f3);
        logic [7:0] op;
        op = 8'h00;
        if (f5 == 5'b10100) begin
            case (f3)
                3'b010:  op = 8'h01;
                3'b001:  op = 8'h04;
                3'b000:  op = 8'h08;
                default: op = 8'h00;
            endcase
        end else if (f5 == 5'b00101) begin
            case (f3)
                3'b000:  op = 8'h40;
                3'b001:  op = 8'h80;
                default: op = 8'h00;
            endcase
        end
        return op;
    endfunction

    function automatic logic is_nan(input logic [Std:0] x);
        return (&x[Std-1:Man+1]) && (|x[Man:0]);
    endfunction

    function automatic logic is_snan(input logic [Std:0] x);
        return is_nan(x) && !x[Man];
    endfunction

    // Returns {nv, data}; NaN and signed-zero cases override the comparator.
    function automatic logic [Std+1:0] correct(input logic [7:0] op, input logic [Std:0] a,
                                               input logic [Std:0] b, input logic res,
                                               input logic [Std:0] mm);
        logic           any_nan;
        logic           any_snan;
        logic           both_zero;
        logic           bit_v;
        logic           nv;
        logic [Std:0]   data;
        logic [Std:0]   qnan;
        any_nan   = is_nan(a) || is_nan(b);
        any_snan  = is_snan(a) || is_snan(b);
        both_zero = (a[Std-1:0] == '0) && (b[Std-1:0] == '0);
        qnan      = {1'b0, {(Exp+1){1'b1}}, 1'b1, {Man{1'b0}}};
        bit_v     = res;
        nv        = 1'b0;
        data      = '0;
        if (op[0]) begin
            if (any_nan) begin
                bit_v = 1'b0;
                nv    = any_snan;
            end else if (both_zero) begin
                bit_v = 1'b1;
            end
            data = {{Std{1'b0}}, bit_v};
        end else if (op[2] || op[3]) begin
            if (any_nan) begin
                bit_v = 1'b0;
                nv    = 1'b1;
            end else if (both_zero) begin
                bit_v = op[3];
            end
            data = {{Std{1'b0}}, bit_v};
        end else if (op[6] || op[7]) begin
            nv = any_snan;
            if (is_nan(a) && is_nan(b)) data = qnan;
            else if (is_nan(a))         data = b;
            else if (is_nan(b))         data = a;
            else                        data = mm;
        end
        return {nv, data};
    endfunction

    assign dec_op    = decode(req_funct5, req_funct3);
    assign fix_p0    = correct(cmp_opcode, cmp_a, cmp_b, cmp_result[0], cmp_minmax);
    assign req_ready = rst_l && (state == IDLE);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state       <= IDLE;
            cmp_opcode  <= '0;
            cmp_a       <= '0;
            cmp_b       <= '0;
            illegal_p0  <= 1'b0;
            tag_p0      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_nv      <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            case (state)
                // Stage p0: register the request and its decoded opcode
                IDLE: begin
                    if (req_valid) begin
                        cmp_a      <= req_rs1;
                        cmp_b      <= req_rs2;
                        cmp_opcode <= dec_op;
                        illegal_p0 <= (dec_op == 8'h00);
                        tag_p0     <= req_tag;
                        state      <= EXEC;
                    end
                end
                // Stage p1: capture the corrected comparator result
                EXEC: begin
                    rsp_valid   <= 1'b1;
                    rsp_data    <= illegal_p0 ? '0 : fix_p0[Std:0];
                    rsp_nv      <= illegal_p0 ? 1'b0 : fix_p0[Std+1];
                    rsp_illegal <= illegal_p0;
                    rsp_tag     <= tag_p0;
                    state       <= RESP;
                end
                // Stage p2: hold the response until it is taken
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        cmp_opcode <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_compare_issue.sv
// Directed-vector bench for fpu_compare_issue; the external comparator's raw output is supplied per vector.
`timescale 1ns/1ps
module tb_fpu_compare_issue;

    logic        clk;
    logic        rst_l;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_funct5;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [3:0]  req_tag;
    logic [7:0]  cmp_opcode;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [31:0] cmp_result;
    logic [31:0] cmp_minmax;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_nv;
    logic        rsp_illegal;
    logic [3:0]  rsp_tag;

    int checks = 0;
    int errors = 0;

    fpu_compare_issue #(.Std(31), .Exp(7), .Man(22), .TAG_W(4)) dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct5(req_funct5), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .cmp_opcode(cmp_opcode), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_result(cmp_result), .cmp_minmax(cmp_minmax),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_nv(rsp_nv), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] f5, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tg, input logic raw_res,
                           input logic [31:0] raw_mm);
        req_valid  = 1'b1;
        req_funct5 = f5;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_tag    = tg;
        cmp_result = {31'd0, raw_res};
        cmp_minmax = raw_mm;
    endtask

    // Full transaction: accept, EXEC, RESP, handshake.
    task automatic do_req(input string name, input logic [4:0] f5, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg,
                          input logic raw_res, input logic [31:0] raw_mm, input logic [7:0] exp_op,
                          input logic [31:0] exp_data, input logic exp_nv, input logic exp_ill);
        int waited = 0;
        while (!req_ready && waited < 10) begin
            tick();
            waited++;
        end
        check({name, " ready"}, {31'd0, req_ready}, 32'd1);
        set_req(f5, f3, a, b, tg, raw_res, raw_mm);
        tick();
        req_valid = 1'b0;
        check({name, " exec_vld"}, {31'd0, rsp_valid}, 32'd0);
        check({name, " op"}, {24'd0, cmp_opcode}, {24'd0, exp_op});
        check({name, " cmp_a"}, cmp_a, a);
        check({name, " cmp_b"}, cmp_b, b);
        tick();
        check({name, " rsp_vld"}, {31'd0, rsp_valid}, 32'd1);
        check({name, " data"}, rsp_data, exp_data);
        check({name, " nv"}, {31'd0, rsp_nv}, {31'd0, exp_nv});
        check({name, " ill"}, {31'd0, rsp_illegal}, {31'd0, exp_ill});
        check({name, " tag"}, {28'd0, rsp_tag}, {28'd0, tg});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, " done_vld"}, {31'd0, rsp_valid}, 32'd0);
        check({name, " op_clr"}, {24'd0, cmp_opcode}, 32'd0);
    endtask

    initial begin
        rst_l      = 1'b0;
        req_valid  = 1'b0;
        req_funct5 = '0;
        req_funct3 = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_tag    = '0;
        cmp_result = '0;
        cmp_minmax = '0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        check("rst ready", {31'd0, req_ready}, 32'd0);
        check("rst vld", {31'd0, rsp_valid}, 32'd0);
        check("rst op", {24'd0, cmp_opcode}, 32'd0);
        check("rst data", rsp_data, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        tick();

        do_req("feq1", 5'b10100, 3'b010, 32'h3F800000, 32'h3F800000, 4'd5, 1'b1, 32'h0, 8'h01, 32'd1, 1'b0, 1'b0);
        do_req("feqz", 5'b10100, 3'b010, 32'h80000000, 32'h00000000, 4'd1, 1'b0, 32'h0, 8'h01, 32'd1, 1'b0, 1'b0);
        do_req("fltz", 5'b10100, 3'b001, 32'h80000000, 32'h00000000, 4'd2, 1'b1, 32'h0, 8'h04, 32'd0, 1'b0, 1'b0);
        do_req("flez", 5'b10100, 3'b000, 32'h80000000, 32'h00000000, 4'd3, 1'b0, 32'h0, 8'h08, 32'd1, 1'b0, 1'b0);
        do_req("fltq", 5'b10100, 3'b001, 32'h7FC00000, 32'h3F800000, 4'd4, 1'b1, 32'h0, 8'h04, 32'd0, 1'b1, 1'b0);
        do_req("feqq", 5'b10100, 3'b010, 32'h7FC00000, 32'h7FC00000, 4'd6, 1'b1, 32'h0, 8'h01, 32'd0, 1'b0, 1'b0);
        do_req("feqs", 5'b10100, 3'b010, 32'h3F800000, 32'h7F800001, 4'd7, 1'b1, 32'h0, 8'h01, 32'd0, 1'b1, 1'b0);
        do_req("fle1", 5'b10100, 3'b000, 32'h40000000, 32'h3F800000, 4'd8, 1'b0, 32'h0, 8'h08, 32'd0, 1'b0, 1'b0);
        do_req("fmins", 5'b00101, 3'b000, 32'h7F800001, 32'h40000000, 4'd9, 1'b0, 32'h7F800001, 8'h40, 32'h40000000, 1'b1, 1'b0);
        do_req("fmaxq", 5'b00101, 3'b001, 32'h7FC00000, 32'h7FC00000, 4'd10, 1'b0, 32'hFFFFFFFF, 8'h80, 32'h7FC00000, 1'b0, 1'b0);
        do_req("fmin", 5'b00101, 3'b000, 32'hBFC00000, 32'h3F800000, 4'd11, 1'b0, 32'hBFC00000, 8'h40, 32'hBFC00000, 1'b0, 1'b0);
        do_req("fmaxb", 5'b00101, 3'b001, 32'h3F800000, 32'h7FC00000, 4'd12, 1'b0, 32'h7FC00000, 8'h80, 32'h3F800000, 1'b0, 1'b0);
        do_req("ill1", 5'b10100, 3'b011, 32'h3F800000, 32'h3F800000, 4'd13, 1'b1, 32'h0, 8'h00, 32'd0, 1'b0, 1'b1);
        do_req("ill2", 5'b00101, 3'b010, 32'h7F800001, 32'h3F800000, 4'd14, 1'b1, 32'h3F800000, 8'h00, 32'd0, 1'b0, 1'b1);

        // Back-pressure: second request held on the bus while the first waits for rsp_ready.
        set_req(5'b10100, 3'b010, 32'h3F800000, 32'h3F800000, 4'd1, 1'b1, 32'h0);
        tick();
        check("bp exec ready", {31'd0, req_ready}, 32'd0);
        set_req(5'b10100, 3'b001, 32'h3F800000, 32'h40000000, 4'd2, 1'b1, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp ready", {31'd0, req_ready}, 32'd0);
            check("bp vld", {31'd0, rsp_valid}, 32'd1);
            check("bp data", rsp_data, 32'd1);
            check("bp tag", {28'd0, rsp_tag}, 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp idle ready", {31'd0, req_ready}, 32'd1);
        check("bp idle vld", {31'd0, rsp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        check("bp2 op", {24'd0, cmp_opcode}, 32'h04);
        check("bp2 cmp_b", cmp_b, 32'h40000000);
        tick();
        check("bp2 vld", {31'd0, rsp_valid}, 32'd1);
        check("bp2 data", rsp_data, 32'd1);
        check("bp2 tag", {28'd0, rsp_tag}, 32'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Asynchronous reset while in EXEC drops the request.
        set_req(5'b10100, 3'b010, 32'h3F800000, 32'h3F800000, 4'd7, 1'b1, 32'h0);
        tick();
        req_valid = 1'b0;
        check("ar exec op", {24'd0, cmp_opcode}, 32'h01);
        rst_l = 1'b0;
        #1;
        check("ar ready", {31'd0, req_ready}, 32'd0);
        check("ar op", {24'd0, cmp_opcode}, 32'd0);
        check("ar cmp_a", cmp_a, 32'd0);
        check("ar vld", {31'd0, rsp_valid}, 32'd0);
        check("ar tag", {28'd0, rsp_tag}, 32'd0);
        #2;
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ar no rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check("ar idle ready", {31'd0, req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
